unified_mem_arbiter: RTL
========================

# unified_mem_arbiter

Shares one single-port `memory` instance between the core's instruction-fetch path and its load/store path, so the design can use a unified instruction/data memory in place of two separate memories. It grants one access per cycle and routes the memory control signals from the selected requester. It captures the memory's combinational read data and returns it to the winning requester one cycle later. Data accesses win ties, and a starvation counter guarantees forward progress for fetch.

## Interface
Parameters:
- `WORD_LENGTH`, 32, width of addresses and data
- `STARVE_LIMIT`, 4, consecutive lost ties before fetch is force-granted; legal range 1..15

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `i_req`  in  1  fetch request; held high until granted
- `i_addr`  in  WORD_LENGTH  fetch address
- `i_gnt`  out  1  fetch granted this cycle (combinational)
- `i_rvalid`  out  1  fetch data valid (registered)
- `i_rdata`  out  WORD_LENGTH  fetch data (registered)
- `d_req`  in  1  load/store request; held high until granted
- `d_addr`  in  WORD_LENGTH  data address
- `d_wdata`  in  WORD_LENGTH  store data
- `d_we`  in  3  store byte-lane code; same encoding as `memory.write_enable`; nonzero means store
- `d_gnt`  out  1  data access granted this cycle (combinational)
- `d_rvalid`  out  1  load data valid or store acknowledge (registered)
- `d_rdata`  out  WORD_LENGTH  load data (registered)
- `mem_address`  out  WORD_LENGTH  to `memory.address`
- `mem_write_data`  out  WORD_LENGTH  to `memory.write_data`
- `mem_write_enable`  out  3  to `memory.write_enable`
- `mem_read_enable`  out  1  to `memory.read_enable`
- `mem_data_out`  in  WORD_LENGTH  from `memory.data_out`; combinational read

## Operation
Handshake:
- A transfer occurs in any cycle where `x_req && x_gnt`.
- At most one grant is high per cycle.
- A requester must keep its request and payload stable until it is granted.

Grant rule (combinational, from the requests and `starve_cnt`):
- Only `d_req` is high: grant data.
- Only `i_req` is high: grant fetch.
- Both are high and `starve_cnt < STARVE_LIMIT`: grant data.
- Both are high and `starve_cnt == STARVE_LIMIT`: grant fetch.

Starvation counter (`starve_cnt`, width `$clog2(STARVE_LIMIT+1)`):
- Increments by 1 when both requests are high and data is granted.
- Clears to 0 when fetch is granted, or when `i_req` is low.
- Otherwise holds.
- Never exceeds `STARVE_LIMIT`.

Memory drive:
- Fetch granted: `mem_address = i_addr`, `mem_read_enable = 1`, `mem_write_enable = 0`, `mem_write_data = 0`.
- Data granted: `mem_address = d_addr`, `mem_write_data = d_wdata`, `mem_write_enable = d_we`, `mem_read_enable = (d_we == 0)`.
- No grant: all memory outputs are 0.

Response FSM (`owner` register), states `IDLE`, `I_RSP`, `D_RSP`:
- Next state is `I_RSP` if fetch was granted this cycle, `D_RSP` if data was granted, `IDLE` otherwise.
- The FSM moves every cycle; back-to-back grants are allowed, giving a throughput of 1 access per cycle.
- `i_rvalid` is high exactly when the state is `I_RSP`; `d_rvalid` is high exactly when the state is `D_RSP`.

Response data:
- On a granted read, `mem_data_out` is captured into the winner's `x_rdata` at the same clock edge.
- On a granted store, `d_rvalid` still pulses as an acknowledge, and `d_rdata` holds its previous value.
- An `x_rdata` register holds its value until that requester's next read.

## Timing
- Grant is combinational, in the same cycle as the request.
- The memory write commits at the edge that ends the grant cycle.
- Read latency is 1 cycle: grant in cycle N, `rvalid` and `rdata` in cycle N+1.
- Reset values: `starve_cnt = 0`, `owner = IDLE`, `i_rvalid = 0`, `d_rvalid = 0`, `i_rdata = 0`, `d_rdata = 0`.
- The combinational outputs go to 0 while `reset` is high, regardless of the requests.
- Reset during an outstanding response: the response is dropped and no `rvalid` appears in the following cycle.
- A grant in the cycle `reset` is asserted is void; no memory write occurs.

## Structure
- Shared package `mem_arb_pkg`:
  - owner state encodings (`IDLE = 2'd0`, `I_RSP = 2'd1`, `D_RSP = 2'd2`)
  - `STORE_NONE = 3'b000`
  - the default `STARVE_LIMIT`
- One sub-module, `arb_starve_counter`:
  - inputs: `clk`, `reset`, `both_req`, `i_won`, `i_req`
  - outputs: `starve_cnt` and `force_i`
  - parameterised by `STARVE_LIMIT`
- The grant mux, memory-drive mux, owner FSM and response registers stay in the top module.

## Test plan
- Fetch only: `i_req = 1`, `i_addr = 0x10`, memory word at 0x10 is `0xDEADBEEF` -> `i_gnt = 1` in the same cycle; next cycle `i_rvalid = 1`, `i_rdata = 0xDEADBEEF`, `d_rvalid = 0`.
- Store then load: store `d_we = 3'b111` of `0x12345678` to 0x40 -> `d_rvalid` pulses one cycle later and `d_rdata` is unchanged. A following load of 0x40 returns `0x12345678` with a 1-cycle latency.
- Continuous contention with `STARVE_LIMIT = 4`: both requests held high -> grant sequence is D,D,D,D,I,D,D,D,D,I…; `starve_cnt` goes 0→4 and then clears on each I grant.
- Back-to-back alternation: D grant in cycle 1, I grant in cycle 2 -> `d_rvalid` in cycle 2 and `i_rvalid` in cycle 3; never both high in one cycle.
- Reset mid-operation: load granted in cycle N, `reset` high in cycle N+1 -> no `d_rvalid`, `d_rdata = 0`, `starve_cnt = 0`, memory outputs 0.
- Idle: no requests -> `mem_read_enable = 0`, `mem_write_enable = 0`, `mem_address = 0`, both grants 0, counter holds 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
// Response-owner encodings, the no-store lane code and the default starvation limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_RSP = 2'd1,
    D_RSP = 2'd2
  } owner_e;

  localparam logic [2:0] STORE_NONE = 3'b000;

  localparam int unsigned DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive ties lost by fetch.
// Raises force_i once fetch has lost STARVE_LIMIT ties in a row.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          both_req,
  input  logic          i_won,
  input  logic          i_req,
  output logic [CW-1:0] starve_cnt,
  output logic          force_i
);

  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!i_req || i_won) begin
      cnt_d = '0;
    end else if (both_req && (cnt_q < LIM)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_cnt = cnt_q;
  assign force_i    = (cnt_q == LIM);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between fetch and load/store.
// Data wins ties; the starvation counter force-grants fetch.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORD_LENGTH  = 32,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_req,
  input  logic [WORD_LENGTH-1:0] i_addr,
  output logic                   i_gnt,
  output logic                   i_rvalid,
  output logic [WORD_LENGTH-1:0] i_rdata,
  input  logic                   d_req,
  input  logic [WORD_LENGTH-1:0] d_addr,
  input  logic [WORD_LENGTH-1:0] d_wdata,
  input  logic [2:0]             d_we,
  output logic                   d_gnt,
  output logic                   d_rvalid,
  output logic [WORD_LENGTH-1:0] d_rdata,
  output logic [WORD_LENGTH-1:0] mem_address,
  output logic [WORD_LENGTH-1:0] mem_write_data,
  output logic [2:0]             mem_write_enable,
  output logic                   mem_read_enable,
  input  logic [WORD_LENGTH-1:0] mem_data_out
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic          force_i;
  logic [CW-1:0] starve_cnt;
  logic          d_load;

  owner_e owner_q, owner_d;

  logic [WORD_LENGTH-1:0] i_rdata_q;
  logic [WORD_LENGTH-1:0] d_rdata_q;

  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .both_req  (i_req && d_req),
    .i_won     (i_gnt),
    .i_req     (i_req),
    .starve_cnt(starve_cnt),
    .force_i   (force_i)
  );

  // Grants are void while reset is held.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      i_gnt = i_req && (!d_req || force_i);
      d_gnt = d_req && !(i_req && force_i);
    end
  end

  assign d_load = (d_we == STORE_NONE);

  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = STORE_NONE;
    mem_read_enable  = 1'b0;
    unique case (1'b1)
      i_gnt: begin
        mem_address     = i_addr;
        mem_read_enable = 1'b1;
      end
      d_gnt: begin
        mem_address      = d_addr;
        mem_write_data   = d_wdata;
        mem_write_enable = d_we;
        mem_read_enable  = d_load;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_d = IDLE;
    unique case (1'b1)
      i_gnt:   owner_d = I_RSP;
      d_gnt:   owner_d = D_RSP;
      default: owner_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= IDLE;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      if (i_gnt) begin
        i_rdata_q <= mem_data_out;
      end
      if (d_gnt && d_load) begin
        d_rdata_q <= mem_data_out;
      end
    end
  end

  // A pending response is dropped as soon as reset rises.
  assign i_rvalid = !reset && (owner_q == I_RSP);
  assign d_rvalid = !reset && (owner_q == D_RSP);
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule
